bvashr_witness_checker: RTL

- Forward evaluator for the bvashr0 inverse Skolem function block. That block maps (s, t) to a witness x intended to satisfy (x >>a s) == t.
- This block takes (s, t, x) and evaluates x >>a s with a serial one-bit-per-cycle shifter. It also evaluates the bvashr0 invertibility condition (IC) and reports whether the witness is correct.
- Sits between the combinational Skolem netlist and the regression harness. Keeps running pass/error counts.

---
 rtl/bvashr_witness_checker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bvashr_witness_checker.sv
// Serial forward evaluator for bvashr0 Skolem witnesses: computes x >>a s,
// the invertibility condition for (s, t), and keeps saturating pass/error counts.
module bvashr_witness_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             match,
    output logic             ic,
    output logic             witness_err,
    output logic             spurious,
    output logic [WIDTH-1:0] shifted,
    output logic [CNT_W-1:0] checked_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] WMAX = (WIDTH + 1)'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CMP,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [WIDTH-1:0]  t_q, t_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              match_q, match_d;
    logic              ic_q, ic_d;
    logic              werr_q, werr_d;
    logic              spur_q, spur_d;
    logic [WIDTH-1:0]  shifted_q, shifted_d;
    logic [CNT_W-1:0]  chk_q, chk_d;
    logic [CNT_W-1:0]  err_q, err_d;

    logic              in_big;
    logic              s_big;
    logic signed [WIDTH-1:0] t_up;
    logic [WIDTH-1:0]  t_back;
    logic              ic_c;
    logic              match_c;

    assign in_big = {1'b0, s} >= WMAX;
    assign s_big  = {1'b0, s_q} >= WMAX;

    // Round-trip test: t survives <<s then >>a s exactly when a witness exists.
    always_comb begin
        t_up   = signed'(t_q << s_q);
        t_back = unsigned'(t_up >>> s_q);
        if (s_big) begin
            ic_c = (t_q == '0) | (t_q == '1);
        end else begin
            ic_c = (t_back == t_q);
        end
    end

    assign match_c = (sr_q == t_q);

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        t_d       = t_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        match_d   = match_q;
        ic_d      = ic_q;
        werr_d    = werr_q;
        spur_d    = spur_q;
        shifted_d = shifted_q;
        chk_d     = chk_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = s;
                    t_d     = t;
                    sr_d    = x;
                    cnt_d   = in_big ? CNT_SAT : CW'(s);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = CMP;
                end else begin
                    sr_d  = {sr_q[WIDTH-1], sr_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CMP: begin
                shifted_d = sr_q;
                match_d   = match_c;
                ic_d      = ic_c;
                werr_d    = ic_c & ~match_c;
                spur_d    = ~ic_c & match_c;
                if (chk_q != '1) begin
                    chk_d = chk_q + CNT_W'(1);
                end
                if ((ic_c ^ match_c) && (err_q != '1)) begin
                    err_d = err_q + CNT_W'(1);
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            t_q       <= '0;
            sr_q      <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            ic_q      <= 1'b0;
            werr_q    <= 1'b0;
            spur_q    <= 1'b0;
            shifted_q <= '0;
            chk_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            t_q       <= t_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            ic_q      <= ic_d;
            werr_q    <= werr_d;
            spur_q    <= spur_d;
            shifted_q <= shifted_d;
            chk_q     <= chk_d;
            err_q     <= err_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign match       = match_q;
    assign ic          = ic_q;
    assign witness_err = werr_q;
    assign spurious    = spur_q;
    assign shifted     = shifted_q;
    assign checked_cnt = chk_q;
    assign err_cnt     = err_q;

endmodule
